// File: rtl/ysyx_icache.sv
// rtl/ysyx_icache.sv - direct-mapped blocking instruction cache between the IFU and the arbiter's IFU port
// Purpose: answers fetch hits in the request cycle. On a miss it refills a whole line
//          using single-beat reads, then serves the still-held request. fence_i invalidates every line.
// Ports:
//   clk, rst                    clock; asynchronous active-low reset
//   ifu_araddr, ifu_arvalid     fetch request from the IFU, held until ifu_rvalid_o
//   ifu_rdata_o, ifu_rvalid_o   instruction word (0 when not valid) and one-cycle valid pulse
//   fence_i                     single-cycle invalidate-all pulse
//   bus_araddr_o, bus_arvalid_o refill beat request towards the arbiter
//   bus_rdata, bus_rvalid       refill beat data and completion from the arbiter
//   hit_cnt_o, miss_cnt_o       wrapping hit / miss counters
module ysyx_icache #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int LINE_WORDS = 4,
    parameter int SETS       = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] ifu_araddr,
    input  logic              ifu_arvalid,
    output logic [DATA_W-1:0] ifu_rdata_o,
    output logic              ifu_rvalid_o,
    input  logic              fence_i,
    output logic [ADDR_W-1:0] bus_araddr_o,
    output logic              bus_arvalid_o,
    input  logic [DATA_W-1:0] bus_rdata,
    input  logic              bus_rvalid,
    output logic [31:0]       hit_cnt_o,
    output logic [31:0]       miss_cnt_o
);

    localparam int WSEL_W = $clog2(LINE_WORDS);
    localparam int OFF    = WSEL_W + 2;
    localparam int IDX    = $clog2(SETS);
    localparam int TAG_W  = ADDR_W - OFF - IDX;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_FILL = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_next_state;

    logic [SETS-1:0]     r_valid;
    logic [TAG_W-1:0]    r_tag  [SETS];
    logic [DATA_W-1:0]   r_data [SETS][LINE_WORDS];

    logic [ADDR_W-1:0]   r_fill_base;
    logic [WSEL_W-1:0]   r_beat;
    logic                r_flush_pending;
    logic                r_post_fill;   // first IDLE cycle after a completed refill
    logic                r_dropped;     // IFU withdrew its request during the refill
    logic [31:0]         r_hit_cnt;
    logic [31:0]         r_miss_cnt;

    logic [WSEL_W-1:0]   w_word;
    logic [IDX-1:0]      w_idx;
    logic [TAG_W-1:0]    w_tag;
    logic [IDX-1:0]      w_fill_idx;
    logic [TAG_W-1:0]    w_fill_tag;
    logic                w_lookup_hit;
    logic                w_post_serve;
    logic                w_hit_evt;
    logic                w_miss_evt;
    logic                w_last_beat;
    logic                w_unused;

    assign w_word     = ifu_araddr[OFF-1:2];
    assign w_idx      = ifu_araddr[OFF+IDX-1:OFF];
    assign w_tag      = ifu_araddr[ADDR_W-1:OFF+IDX];
    assign w_fill_idx = r_fill_base[OFF+IDX-1:OFF];
    assign w_fill_tag = r_fill_base[ADDR_W-1:OFF+IDX];
    assign w_unused   = &{1'b0, ifu_araddr[1:0]};

    assign w_lookup_hit = r_valid[w_idx] && (r_tag[w_idx] == w_tag);

    // The request that caused the refill is answered straight from the freshly written
    // line even when a fence kept it from being validated; it is not a new hit.
    assign w_post_serve = r_post_fill && !r_dropped && ifu_arvalid;

    assign hit_cnt_o  = r_hit_cnt;
    assign miss_cnt_o = r_miss_cnt;

    always_comb begin
        w_next_state  = r_state;
        ifu_rvalid_o  = 1'b0;
        ifu_rdata_o   = '0;
        bus_arvalid_o = 1'b0;
        bus_araddr_o  = '0;
        w_hit_evt     = 1'b0;
        w_miss_evt    = 1'b0;
        w_last_beat   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (ifu_arvalid) begin
                    if (w_post_serve || w_lookup_hit) begin
                        ifu_rvalid_o = 1'b1;
                        ifu_rdata_o  = r_data[w_idx][w_word];
                        w_hit_evt    = !w_post_serve;
                    end else begin
                        w_miss_evt   = 1'b1;
                        w_next_state = S_FILL;
                    end
                end
            end
            S_FILL: begin
                bus_arvalid_o = 1'b1;
                bus_araddr_o  = r_fill_base + ADDR_W'({r_beat, 2'b00});
                if (bus_rvalid && (r_beat == WSEL_W'(LINE_WORDS - 1))) begin
                    w_last_beat  = 1'b1;
                    w_next_state = S_IDLE;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state         <= S_IDLE;
            r_valid         <= '0;
            r_fill_base     <= '0;
            r_beat          <= '0;
            r_flush_pending <= 1'b0;
            r_post_fill     <= 1'b0;
            r_dropped       <= 1'b0;
            r_hit_cnt       <= '0;
            r_miss_cnt      <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_hit_evt) begin
                r_hit_cnt <= r_hit_cnt + 32'd1;
            end
            if (w_miss_evt) begin
                r_miss_cnt <= r_miss_cnt + 32'd1;
            end
            case (r_state)
                S_IDLE: begin
                    r_post_fill <= 1'b0;
                    if (w_miss_evt) begin
                        r_fill_base     <= {ifu_araddr[ADDR_W-1:OFF], {OFF{1'b0}}};
                        r_beat          <= '0;
                        r_dropped       <= 1'b0;
                        r_flush_pending <= 1'b0;
                        r_valid[w_idx]  <= 1'b0;
                    end
                    // Same-cycle hits were already served from the pre-flush contents.
                    if (fence_i) begin
                        r_valid <= '0;
                    end
                end
                S_FILL: begin
                    if (!ifu_arvalid) begin
                        r_dropped <= 1'b1;
                    end
                    if (fence_i) begin
                        r_flush_pending <= 1'b1;
                    end
                    if (bus_rvalid) begin
                        r_beat <= r_beat + WSEL_W'(1);
                        if (w_last_beat) begin
                            r_post_fill     <= 1'b1;
                            r_flush_pending <= 1'b0;
                            // A fence seen at any point of the refill, including this
                            // final beat, leaves the new line invalid.
                            if (r_flush_pending || fence_i) begin
                                r_valid <= '0;
                            end else begin
                                r_valid[w_fill_idx] <= 1'b1;
                            end
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Line storage needs no reset: nothing is readable until its valid bit is set
    // or it has just been refilled.
    always_ff @(posedge clk) begin
        if ((r_state == S_FILL) && bus_rvalid) begin
            r_data[w_fill_idx][r_beat] <= bus_rdata;
            if (w_last_beat) begin
                r_tag[w_fill_idx] <= w_fill_tag;
            end
        end
    end

endmodule

// File: tb/tb_ysyx_icache.sv
// tb/tb_ysyx_icache.sv - self-checking bench for ysyx_icache
module tb_ysyx_icache;

    localparam int LW = 4;
    localparam int NS = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] ifu_araddr = '0;
    logic        ifu_arvalid = 1'b0;
    logic [31:0] ifu_rdata_o;
    logic        ifu_rvalid_o;
    logic        fence_i;
    logic [31:0] bus_araddr_o;
    logic        bus_arvalid_o;
    logic [31:0] bus_rdata = '0;
    logic        bus_rvalid = 1'b0;
    logic [31:0] hit_cnt_o;
    logic [31:0] miss_cnt_o;

    logic fence_dir = 1'b0;
    logic fence_rnd = 1'b0;
    logic fence_bus = 1'b0;
    logic rnd_fence_en = 1'b0;
    assign fence_i = fence_dir | fence_rnd | fence_bus;

    int total = 0;
    int bad   = 0;

    int stall_beat = -1;
    int fence_beat = -1;
    int beat_no    = 0;
    int wait_cnt   = 0;

    ysyx_icache dut (
        .clk           (clk),
        .rst           (rst),
        .ifu_araddr    (ifu_araddr),
        .ifu_arvalid   (ifu_arvalid),
        .ifu_rdata_o   (ifu_rdata_o),
        .ifu_rvalid_o  (ifu_rvalid_o),
        .fence_i       (fence_i),
        .bus_araddr_o  (bus_araddr_o),
        .bus_arvalid_o (bus_arvalid_o),
        .bus_rdata     (bus_rdata),
        .bus_rvalid    (bus_rvalid),
        .hit_cnt_o     (hit_cnt_o),
        .miss_cnt_o    (miss_cnt_o)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a * 32'd3 + 32'h0000_1111;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h t=%0t", name, got, want, $time);
        end
    endtask

    // Memory behind the arbiter: random beat latency, optional long stall, optional
    // fence pulse coinciding with a chosen beat.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            fence_bus = 1'b0;
            if (!rst) begin
                bus_rvalid = 1'b0;
                beat_no    = 0;
                wait_cnt   = $urandom_range(0, 3);
            end else if (bus_rvalid) begin
                bus_rvalid = 1'b0;
                bus_rdata  = $urandom;
            end else if (bus_arvalid_o) begin
                if (wait_cnt > 0) begin
                    wait_cnt--;
                end else begin
                    bus_rvalid = 1'b1;
                    bus_rdata  = mem_word(bus_araddr_o);
                    if (beat_no == fence_beat) fence_bus = 1'b1;
                    beat_no  = (beat_no + 1) % LW;
                    wait_cnt = (beat_no == stall_beat) ? 10 : $urandom_range(0, 3);
                end
            end
        end
    end

    always @(posedge clk) begin
        #1;
        fence_rnd = rnd_fence_en && ($urandom_range(0, 15) == 0);
    end

    // Reference model: which memory line each set holds, plus the refill in progress.
    int          resident [int];
    bit          m_fill = 0;
    bit          m_post = 0;
    bit          m_dropped = 0;
    bit          m_flush = 0;
    int          m_beats = 0;
    logic [31:0] m_base = '0;
    int          m_hits = 0;
    int          m_misses = 0;
    logic        e_rv, e_bv;
    logic [31:0] e_rd, e_ba;
    bit          do_hit, do_miss;

    always @(negedge clk) begin
        e_rv = 1'b0; e_rd = '0; e_bv = 1'b0; e_ba = '0;
        do_hit = 0; do_miss = 0;
        if (!rst) begin
            resident.delete();
            m_fill = 0; m_post = 0; m_dropped = 0; m_flush = 0; m_beats = 0;
            m_hits = 0; m_misses = 0;
        end else if (!m_fill) begin
            if (ifu_arvalid) begin
                int s;
                int ln;
                s  = int'((ifu_araddr >> 4) % NS);
                ln = int'(ifu_araddr >> 4);
                if (m_post && !m_dropped) begin
                    e_rv = 1'b1; e_rd = mem_word(ifu_araddr);
                end else if (resident.exists(s) && resident[s] == ln) begin
                    e_rv = 1'b1; e_rd = mem_word(ifu_araddr); do_hit = 1;
                end else begin
                    do_miss = 1;
                    m_fill = 1; m_base = ifu_araddr & ~32'hF; m_beats = 0;
                    m_dropped = 0; m_flush = 0;
                    resident.delete(s);
                end
            end
            if (fence_i) resident.delete();
            m_post = 0;
        end else begin
            e_bv = 1'b1;
            e_ba = m_base + 32'(4 * m_beats);
            if (!ifu_arvalid) m_dropped = 1;
            if (fence_i) m_flush = 1;
            if (bus_rvalid) begin
                m_beats++;
                if (m_beats == LW) begin
                    m_fill = 0; m_post = 1;
                    if (m_flush) resident.delete();
                    else resident[int'((m_base >> 4) % NS)] = int'(m_base >> 4);
                end
            end
        end
        check("rvalid", 32'(ifu_rvalid_o), 32'(e_rv));
        check("rdata", ifu_rdata_o, e_rd);
        check("bus_arvalid", 32'(bus_arvalid_o), 32'(e_bv));
        check("bus_araddr", bus_araddr_o, e_ba);
        check("hit_cnt", hit_cnt_o, 32'(m_hits));
        check("miss_cnt", miss_cnt_o, 32'(m_misses));
        if (do_hit) m_hits++;
        if (do_miss) m_misses++;
    end

    task automatic fetch(input logic [31:0] a, input int drop_after,
                         output logic [31:0] d, output int lat);
        int n;
        ifu_araddr = a; ifu_arvalid = 1'b1; d = '0; lat = 0;
        forever begin
            @(negedge clk);
            if (ifu_rvalid_o) begin
                d = ifu_rdata_o;
                @(posedge clk); #1;
                ifu_arvalid = 1'b0;
                return;
            end
            if (lat == drop_after) begin
                @(posedge clk); #1;
                ifu_arvalid = 1'b0;
                n = 0;
                @(negedge clk);
                while (bus_arvalid_o && n < 300) begin
                    @(negedge clk);
                    n++;
                end
                if (bus_arvalid_o) begin
                    total++; bad++;
                    $display("FAIL drop_timeout addr=%h", a);
                end
                @(posedge clk); #1;
                return;
            end
            lat++;
            if (lat > 300) begin
                total++; bad++;
                $display("FAIL fetch_timeout addr=%h", a);
                ifu_arvalid = 1'b0;
                return;
            end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog t=%0t", $time);
        $fatal(1);
    end

    initial begin
        logic [31:0] d;
        int lat;
        logic [31:0] a;

        repeat (3) @(posedge clk);
        #1;
        check("rst_rvalid", 32'(ifu_rvalid_o), 32'd0);
        check("rst_bus_arvalid", 32'(bus_arvalid_o), 32'd0);
        check("rst_hit", hit_cnt_o, 32'd0);
        check("rst_miss", miss_cnt_o, 32'd0);
        rst = 1'b1;

        // cold miss then hit
        fetch(32'h3000_0008, -1, d, lat);
        check("cold_data", d, 32'h9000_1129);
        check("cold_miss", miss_cnt_o, 32'd1);
        check("cold_hit", hit_cnt_o, 32'd0);
        fetch(32'h3000_000C, -1, d, lat);
        check("hit_lat", 32'(lat), 32'd0);
        check("hit_data", d, 32'h9000_1135);
        check("hit_cnt1", hit_cnt_o, 32'd1);

        // conflict eviction
        fetch(32'h3000_0000, -1, d, lat);
        fetch(32'h3000_0100, -1, d, lat);
        fetch(32'h3000_0000, -1, d, lat);
        check("evict_miss", miss_cnt_o, 32'd3);
        check("evict_hit", hit_cnt_o, 32'd2);

        // fence in IDLE
        fence_dir = 1'b1;
        @(posedge clk); #1;
        fence_dir = 1'b0;
        fetch(32'h3000_0004, -1, d, lat);
        check("fence_idle_missed", 32'(lat > 0), 32'd1);
        check("fence_idle_miss", miss_cnt_o, 32'd4);

        // fence during the refill
        fence_beat = 2;
        fetch(32'h3000_0200, -1, d, lat);
        fence_beat = -1;
        check("fence_fill_data", d, 32'h9000_1711);
        fetch(32'h3000_0204, -1, d, lat);
        check("fence_fill_missed", 32'(lat > 0), 32'd1);
        check("fence_fill_miss", miss_cnt_o, 32'd6);

        // arbiter stall
        stall_beat = 2;
        fetch(32'h3000_0310, -1, d, lat);
        stall_beat = -1;
        check("stall_lat", 32'(lat >= 11), 32'd1);

        // redirect mid-fill
        fetch(32'h3000_0420, 2, d, lat);
        fetch(32'h3000_0424, -1, d, lat);
        check("drop_hit_lat", 32'(lat), 32'd0);
        check("drop_hits", hit_cnt_o, 32'd3);
        check("drop_miss", miss_cnt_o, 32'd8);

        // randomized traffic
        rnd_fence_en = 1'b1;
        for (int i = 0; i < 400; i++) begin
            a = 32'h3000_0000 | (32'($urandom_range(0, 3)) << 8)
                | (32'($urandom_range(0, 15)) << 4) | (32'($urandom_range(0, 3)) << 2);
            fence_beat = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 3)) : -1;
            stall_beat = ($urandom_range(0, 11) == 0) ? int'($urandom_range(0, 3)) : -1;
            fetch(a, ($urandom_range(0, 9) == 0) ? 2 : -1, d, lat);
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end
        end
        rnd_fence_en = 1'b0;
        fence_beat = -1;
        stall_beat = -1;
        @(posedge clk); #1;

        // asynchronous reset during a refill
        fetch(32'h3000_0550, -1, d, lat);
        ifu_araddr = 32'h3000_0750; ifu_arvalid = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        check("arst_rvalid", 32'(ifu_rvalid_o), 32'd0);
        check("arst_rdata", ifu_rdata_o, 32'd0);
        check("arst_bus_arvalid", 32'(bus_arvalid_o), 32'd0);
        check("arst_bus_araddr", bus_araddr_o, 32'd0);
        check("arst_hit", hit_cnt_o, 32'd0);
        check("arst_miss", miss_cnt_o, 32'd0);
        ifu_arvalid = 1'b0;
        @(posedge clk); #2;
        rst = 1'b1;
        fetch(32'h3000_0750, -1, d, lat);
        check("arst_refill_missed", 32'(lat > 0), 32'd1);
        fetch(32'h3000_0550, -1, d, lat);
        check("arst_old_missed", 32'(lat > 0), 32'd1);
        check("arst_miss_cnt", miss_cnt_o, 32'd2);
        check("arst_hit_cnt", hit_cnt_o, 32'd0);

        repeat (2) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
